// File: rtl/mem_access_ctrl.sv
// Bus master that runs one CPU request at a time against an asynchronous memory.
// It uses an en/MFC handshake with a synchronised MFC and a bounded wait in every phase.
module mem_access_ctrl #(
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 16,
    parameter int TIMEOUT     = 255,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_rw,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_busy,
    output logic              cpu_done,
    output logic              cpu_err,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              mem_en,
    output logic              mem_rw,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_in,
    input  logic [DATA_W-1:0] mem_out,
    input  logic              mem_mfc
);

    localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_WAIT,
        S_RELEASE,
        S_DONE
    } state_t;

    state_t                 state_reg;
    logic [CNT_W-1:0]       cnt_reg;
    logic                   err_reg;
    logic [SYNC_STAGES-1:0] sync_reg;
    logic                   mfc_s;

    // mem_mfc is asynchronous; only the last synchroniser stage is trusted.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_reg <= '0;
        end else begin
            sync_reg <= {sync_reg[SYNC_STAGES-2:0], mem_mfc};
        end
    end

    assign mfc_s = sync_reg[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= S_IDLE;
            cnt_reg   <= '0;
            err_reg   <= 1'b0;
            mem_en    <= 1'b0;
            mem_rw    <= 1'b1;
            mem_addr  <= '0;
            mem_in    <= '0;
            cpu_busy  <= 1'b0;
            cpu_done  <= 1'b0;
            cpu_err   <= 1'b0;
            cpu_rdata <= '0;
        end else begin
            cpu_done <= 1'b0;
            cpu_err  <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    if (cpu_req) begin
                        mem_addr  <= cpu_addr;
                        mem_rw    <= cpu_rw;
                        mem_in    <= cpu_wdata;
                        err_reg   <= 1'b0;
                        cpu_busy  <= 1'b1;
                        state_reg <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    mem_en    <= 1'b1;
                    cnt_reg   <= '0;
                    state_reg <= S_WAIT;
                end
                S_WAIT: begin
                    // A stale MFC still high from before is accepted as completion.
                    if (mfc_s) begin
                        if (mem_rw) begin
                            cpu_rdata <= mem_out;
                        end
                        mem_en    <= 1'b0;
                        cnt_reg   <= '0;
                        state_reg <= S_RELEASE;
                    end else if (cnt_reg == CNT_MAX) begin
                        err_reg   <= 1'b1;
                        mem_en    <= 1'b0;
                        cnt_reg   <= '0;
                        state_reg <= S_RELEASE;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                S_RELEASE: begin
                    // Wait for MFC to drop so it cannot complete the next access.
                    if (!mfc_s) begin
                        cpu_done  <= 1'b1;
                        cpu_err   <= err_reg;
                        state_reg <= S_DONE;
                    end else if (cnt_reg == CNT_MAX) begin
                        err_reg   <= 1'b1;
                        cpu_done  <= 1'b1;
                        cpu_err   <= 1'b1;
                        state_reg <= S_DONE;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                S_DONE: begin
                    cpu_busy  <= 1'b0;
                    state_reg <= S_IDLE;
                end
                default: begin
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl with a small behavioural memory model.
// The model can produce delayed, combinational, missing or stuck MFC.
module tb_mem_access_ctrl;

    localparam int AW = 16;
    localparam int DW = 16;

    localparam logic [1:0] M_DELAY = 2'd0;
    localparam logic [1:0] M_COMB  = 2'd1;
    localparam logic [1:0] M_LOW   = 2'd2;
    localparam logic [1:0] M_STUCK = 2'd3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cpu_req = 1'b0;
    logic          cpu_rw = 1'b1;
    logic [AW-1:0] cpu_addr = '0;
    logic [DW-1:0] cpu_wdata = '0;
    logic          cpu_busy, cpu_done, cpu_err;
    logic [DW-1:0] cpu_rdata;
    logic          mem_en, mem_rw;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_in, mem_out;
    logic          mem_mfc;

    mem_access_ctrl #(
        .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(8), .SYNC_STAGES(2)
    ) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_rw(cpu_rw), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_busy(cpu_busy), .cpu_done(cpu_done), .cpu_err(cpu_err), .cpu_rdata(cpu_rdata),
        .mem_en(mem_en), .mem_rw(mem_rw), .mem_addr(mem_addr), .mem_in(mem_in),
        .mem_out(mem_out), .mem_mfc(mem_mfc)
    );

    always #5 clk = ~clk;

    // Memory model and monitors
    logic [1:0]    mode = M_DELAY;
    logic [DW-1:0] mem_model [256];
    logic          en_prev = 1'b0;
    int            en_cnt = 0;
    logic          stuck_reg = 1'b0;
    int            access_total = 0, write_total = 0, en_cycles_total = 0;
    int            done_total = 0, unstable_total = 0;
    logic [AW-1:0] last_waddr = '0;
    logic [DW-1:0] last_wdata = '0;
    logic          busy_prev = 1'b0;
    logic [AW-1:0] addr_prev = '0;
    logic          rw_prev = 1'b0;
    logic [DW-1:0] in_prev = '0;

    assign mem_out = mem_model[mem_addr[7:0]];

    always_comb begin
        mem_mfc = 1'b0;
        case (mode)
            M_DELAY: mem_mfc = mem_en && (en_cnt >= 2);
            M_COMB:  mem_mfc = mem_en;
            M_LOW:   mem_mfc = 1'b0;
            M_STUCK: mem_mfc = mem_en || stuck_reg;
            default: mem_mfc = 1'b0;
        endcase
    end

    always @(posedge clk) begin
        if (rst) begin
            mem_model[3] <= 16'h0001;
        end
        en_prev <= mem_en;
        en_cnt  <= mem_en ? en_cnt + 1 : 0;
        stuck_reg <= (mode == M_STUCK) ? (stuck_reg || mem_en) : 1'b0;
        if (mem_en && !en_prev) begin
            access_total <= access_total + 1;
            if (!mem_rw) begin
                mem_model[mem_addr[7:0]] <= mem_in;
                write_total <= write_total + 1;
                last_waddr  <= mem_addr;
                last_wdata  <= mem_in;
            end
        end
        if (mem_en) en_cycles_total <= en_cycles_total + 1;
        if (cpu_done) done_total <= done_total + 1;
        if (cpu_busy && busy_prev &&
            (mem_addr != addr_prev || mem_rw != rw_prev || mem_in != in_prev))
            unstable_total <= unstable_total + 1;
        busy_prev <= cpu_busy;
        addr_prev <= mem_addr;
        rw_prev   <= mem_rw;
        in_prev   <= mem_in;
    end

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge in IDLE; returns at the negedge where cpu_done is seen.
    // k counts negedges from the request; 0 means the budget expired.
    task automatic transact(input logic rw, input logic [AW-1:0] addr,
                            input logic [DW-1:0] wdata, input int budget,
                            output int k, output logic busy1);
        k = 0;
        busy1 = 1'b0;
        cpu_req = 1'b1;
        cpu_rw = rw;
        cpu_addr = addr;
        cpu_wdata = wdata;
        for (int i = 1; i <= budget; i++) begin
            @(negedge clk);
            if (i == 1) begin
                cpu_req = 1'b0;
                busy1 = cpu_busy;
            end
            if (cpu_done) begin
                k = i;
                break;
            end
        end
    endtask

    initial begin
        int k, k2, d0, a0, w0, e0, u0;
        logic b1;

        // Reset state
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("rst_mem_en", {31'd0, mem_en}, 32'd0);
        check("rst_mem_rw", {31'd0, mem_rw}, 32'd1);
        check("rst_mem_addr", {16'd0, mem_addr}, 32'd0);
        check("rst_mem_in", {16'd0, mem_in}, 32'd0);
        check("rst_busy", {31'd0, cpu_busy}, 32'd0);
        check("rst_done", {31'd0, cpu_done}, 32'd0);
        check("rst_err", {31'd0, cpu_err}, 32'd0);
        check("rst_rdata", {16'd0, cpu_rdata}, 32'd0);
        @(negedge clk);

        // 1: read 0x0003, MFC two cycles after en
        d0 = done_total; a0 = access_total; u0 = unstable_total;
        transact(1'b1, 16'h0003, 16'h0000, 40, k, b1);
        $display("txn1 read addr=0003 k=%0d err=%0d rdata=%h", k, cpu_err, cpu_rdata);
        check("t1_busy_after_accept", {31'd0, b1}, 32'd1);
        check("t1_latency", k, 32'd10);
        check("t1_err", {31'd0, cpu_err}, 32'd0);
        check("t1_rdata", {16'd0, cpu_rdata}, 32'h0001);
        check("t1_mem_rw", {31'd0, mem_rw}, 32'd1);
        check("t1_mem_addr", {16'd0, mem_addr}, 32'h0003);
        @(negedge clk);
        check("t1_busy_after_done", {31'd0, cpu_busy}, 32'd0);
        check("t1_done_low", {31'd0, cpu_done}, 32'd0);
        check("t1_done_count", done_total - d0, 32'd1);
        check("t1_access_count", access_total - a0, 32'd1);
        check("t1_stable", unstable_total - u0, 32'd0);

        // 2: write 0xBEEF to 0x0040, then read it back
        d0 = done_total; w0 = write_total;
        transact(1'b0, 16'h0040, 16'hBEEF, 40, k, b1);
        $display("txn2a write addr=0040 data=BEEF k=%0d err=%0d", k, cpu_err);
        check("t2_wr_latency", k, 32'd10);
        check("t2_wr_err", {31'd0, cpu_err}, 32'd0);
        check("t2_wr_rdata_held", {16'd0, cpu_rdata}, 32'h0001);
        @(negedge clk);
        check("t2_write_count", write_total - w0, 32'd1);
        check("t2_write_addr", {16'd0, last_waddr}, 32'h0040);
        check("t2_write_data", {16'd0, last_wdata}, 32'hBEEF);
        transact(1'b1, 16'h0040, 16'h0000, 40, k, b1);
        $display("txn2b read addr=0040 k=%0d err=%0d rdata=%h", k, cpu_err, cpu_rdata);
        check("t2_rd_rdata", {16'd0, cpu_rdata}, 32'hBEEF);
        @(negedge clk);
        check("t2_done_count", done_total - d0, 32'd2);

        // 3: timeout, MFC never arrives
        mode = M_LOW;
        e0 = en_cycles_total;
        transact(1'b1, 16'h0003, 16'h0000, 40, k, b1);
        $display("txn3 read addr=0003 (no MFC) k=%0d err=%0d rdata=%h", k, cpu_err, cpu_rdata);
        check("t3_latency", k, 32'd12);
        check("t3_done", {31'd0, cpu_done}, 32'd1);
        check("t3_err", {31'd0, cpu_err}, 32'd1);
        check("t3_rdata_held", {16'd0, cpu_rdata}, 32'hBEEF);
        @(negedge clk);
        check("t3_en_cycles", en_cycles_total - e0, 32'd9);
        check("t3_busy_after", {31'd0, cpu_busy}, 32'd0);
        check("t3_err_clear", {31'd0, cpu_err}, 32'd0);

        // 4: minimum latency, then cpu_req held high across DONE
        mode = M_COMB;
        transact(1'b1, 16'h0003, 16'h0000, 40, k, b1);
        $display("txn4a read addr=0003 (comb MFC) k=%0d rdata=%h", k, cpu_rdata);
        check("t4_min_latency", k, 32'd8);
        check("t4_rdata", {16'd0, cpu_rdata}, 32'h0001);
        @(negedge clk);
        d0 = done_total; a0 = access_total;
        cpu_req = 1'b1; cpu_rw = 1'b1; cpu_addr = 16'h0040;
        k = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (cpu_done) begin k = i; break; end
        end
        check("t4_b2b_first", k, 32'd8);
        @(negedge clk);
        @(negedge clk);
        cpu_req = 1'b0;
        k2 = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (cpu_done) begin k2 = i; break; end
        end
        $display("txn4b back-to-back reads addr=0040 k1=%0d k2=%0d rdata=%h", k, k2, cpu_rdata);
        check("t4_b2b_second", k2, 32'd7);
        check("t4_b2b_rdata", {16'd0, cpu_rdata}, 32'hBEEF);
        repeat (12) @(negedge clk);
        check("t4_b2b_accesses", access_total - a0, 32'd2);
        check("t4_b2b_dones", done_total - d0, 32'd2);

        // 5: reset while WAIT has mem_en high
        mode = M_DELAY;
        d0 = done_total;
        cpu_req = 1'b1; cpu_rw = 1'b1; cpu_addr = 16'h0003;
        @(negedge clk);
        cpu_req = 1'b0;
        @(negedge clk);
        check("t5_en_before_rst", {31'd0, mem_en}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        $display("txn5 reset mid-wait en=%0d busy=%0d rdata=%h", mem_en, cpu_busy, cpu_rdata);
        check("t5_en", {31'd0, mem_en}, 32'd0);
        check("t5_busy", {31'd0, cpu_busy}, 32'd0);
        check("t5_rdata", {16'd0, cpu_rdata}, 32'd0);
        repeat (12) @(negedge clk);
        check("t5_no_done", done_total - d0, 32'd0);
        transact(1'b1, 16'h0003, 16'h0000, 40, k, b1);
        $display("txn5b read addr=0003 k=%0d err=%0d rdata=%h", k, cpu_err, cpu_rdata);
        check("t5_fresh_latency", k, 32'd10);
        check("t5_fresh_err", {31'd0, cpu_err}, 32'd0);
        check("t5_fresh_rdata", {16'd0, cpu_rdata}, 32'h0001);
        @(negedge clk);

        // 6: MFC stuck high after en drops
        mode = M_STUCK;
        transact(1'b1, 16'h0040, 16'h0000, 40, k, b1);
        $display("txn6 read addr=0040 (stuck MFC) k=%0d err=%0d rdata=%h", k, cpu_err, cpu_rdata);
        check("t6_latency", k, 32'd14);
        check("t6_err", {31'd0, cpu_err}, 32'd1);
        check("t6_rdata", {16'd0, cpu_rdata}, 32'hBEEF);
        @(negedge clk);
        check("t6_busy_after", {31'd0, cpu_busy}, 32'd0);
        mode = M_COMB;
        repeat (4) @(negedge clk);
        transact(1'b1, 16'h0003, 16'h0000, 40, k, b1);
        $display("txn6b read addr=0003 k=%0d err=%0d rdata=%h", k, cpu_err, cpu_rdata);
        check("t6_recover_latency", k, 32'd8);
        check("t6_recover_err", {31'd0, cpu_err}, 32'd0);
        check("t6_recover_rdata", {16'd0, cpu_rdata}, 32'h0001);
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
